// File: rtl/instr_loader.sv
// Boot-time instruction-memory loader: receives a word-count header and program words over a
// UART byte stream, writes them to instruction memory and reports a one-byte status back.
module instr_loader #(
    parameter int unsigned      DATA_W    = 32,
    parameter int unsigned      ADDR_W    = 32,
    parameter int unsigned      DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]       ACK_BYTE  = 8'hAA,
    parameter logic [7:0]       ERR_BYTE  = 8'hEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              restart,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       word_cnt
);

    localparam int unsigned NB      = DATA_W / 8;
    localparam int unsigned IDX_MAX = (NB > 4) ? NB : 4;
    localparam int unsigned IDX_W   = $clog2(IDX_MAX);
    localparam logic [IDX_W-1:0] LAST_HDR  = IDX_W'(3);
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NB - 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_STAT,
        S_ERR_TX,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        n;
    logic [31:0]        hdr_next;
    logic [DATA_W-1:0]  asm_word;
    logic [DATA_W-1:0]  asm_next;
    logic               xfer;

    // Next-state decode plus the byte-merged views of the header and word registers.
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        hdr_next   = n;
        hdr_next[{idx[1:0], 3'b000} +: 8] = rx_data;
        asm_next   = asm_word;
        asm_next[{idx, 3'b000} +: 8] = rx_data;

        case (state)
            S_HDR: begin
                rx_ready = 1'b1;
                if (rx_valid && idx == LAST_HDR) begin
                    if (hdr_next > 32'(DEPTH))
                        state_next = S_ERR_TX;
                    else if (hdr_next == 32'd0)
                        state_next = S_STAT;
                    else
                        state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                rx_ready = 1'b1;
                if (rx_valid && idx == LAST_BYTE && (word_cnt + 32'd1) == n)
                    state_next = S_STAT;
            end
            S_STAT: begin
                if (tx_valid && tx_ready)
                    state_next = S_DONE;
            end
            S_ERR_TX: begin
                if (tx_valid && tx_ready)
                    state_next = S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (restart)
                    state_next = S_HDR;
            end
            default: state_next = S_HDR;
        endcase
    end

    assign xfer = rx_valid && rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_HDR;
            we       <= 1'b0;
            addr     <= BASE_ADDR;
            dout     <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            word_cnt <= 32'd0;
            n        <= 32'd0;
            idx      <= '0;
            asm_word <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_next;
            we       <= 1'b0;
            busy     <= (state_next == S_HDR) || (state_next == S_LOAD) || (state_next == S_STAT);
            done     <= (state_next == S_DONE);
            error    <= (state_next == S_ERROR);
            tx_valid <= (state_next == S_STAT) || (state_next == S_ERR_TX);
            if (state_next == S_STAT)
                tx_data <= ACK_BYTE;
            else if (state_next == S_ERR_TX)
                tx_data <= ERR_BYTE;

            case (state)
                S_HDR: begin
                    if (xfer) begin
                        n   <= hdr_next;
                        idx <= (idx == LAST_HDR) ? '0 : idx + IDX_W'(1);
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        asm_word <= asm_next;
                        if (idx == LAST_BYTE) begin
                            // Word complete: write it on the following cycle at the pre-increment slot.
                            idx      <= '0;
                            we       <= 1'b1;
                            dout     <= asm_next;
                            addr     <= BASE_ADDR + ADDR_W'({word_cnt, 2'b00});
                            word_cnt <= word_cnt + 32'd1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (restart) begin
                        word_cnt <= 32'd0;
                        idx      <= '0;
                        n        <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
